// File: rtl/result_window_accum_pkg.sv
// Shared types and defaults for the result window accumulator.
package result_window_accum_pkg;

  localparam int unsigned DefDataW  = 53;
  localparam int unsigned DefWindow = 8;
  // Wide enough to hold a count of 256 (the largest supported window).
  localparam int unsigned CountW    = 9;

  typedef enum logic {
    Accum = 1'b0,
    Emit  = 1'b1
  } state_e;

endpackage

// File: rtl/window_stat_reg.sv
// Running sum / maximum / sample count for one window.
// The *_next outputs show the statistics including this cycle's accepted sample.
module window_stat_reg
  import result_window_accum_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned SUM_W  = DefDataW + $clog2(DefWindow)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [DATA_W-1:0] data,
  output logic [SUM_W-1:0]  sum_next,
  output logic [DATA_W-1:0] max_next,
  output logic [CountW-1:0] count_next
);

  logic [SUM_W-1:0]  sum_q;
  logic [DATA_W-1:0] max_q;
  logic [CountW-1:0] count_q;

  always_comb begin
    sum_next   = sum_q;
    max_next   = max_q;
    count_next = count_q;
    if (accept) begin
      sum_next   = sum_q + SUM_W'(data);
      max_next   = (data > max_q) ? data : max_q;
      count_next = count_q + CountW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      max_q   <= '0;
      count_q <= '0;
    end else if (clear) begin
      sum_q   <= '0;
      max_q   <= '0;
      count_q <= '0;
    end else begin
      sum_q   <= sum_next;
      max_q   <= max_next;
      count_q <= count_next;
    end
  end

endmodule

// File: rtl/result_window_accum.sv
// Accumulates result words into fixed-size windows and emits sum/max/count
// summaries over a valid/ready handshake; flush closes a partial window early.
module result_window_accum
  import result_window_accum_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned WINDOW = DefWindow,
  localparam int unsigned SUM_W = DATA_W + $clog2(WINDOW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_max,
  output logic [CountW-1:0] out_count,
  output logic              out_partial
);

  state_e state_q, state_d;
  logic   ready_q;
  logic   accept;
  logic   load;
  logic   load_partial;
  logic   clear;

  logic [SUM_W-1:0]  sum_next;
  logic [DATA_W-1:0] max_next;
  logic [CountW-1:0] count_next;

  logic [SUM_W-1:0]  out_sum_q;
  logic [DATA_W-1:0] out_max_q;
  logic [CountW-1:0] out_count_q;
  logic              out_partial_q;

  // ready_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = ready_q && (state_q == Accum);
  assign out_valid = (state_q == Emit);
  assign accept    = in_valid && in_ready;

  window_stat_reg #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_stat (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .accept     (accept),
    .data       (in_data),
    .sum_next   (sum_next),
    .max_next   (max_next),
    .count_next (count_next)
  );

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    load_partial = 1'b0;
    clear        = 1'b0;
    case (state_q)
      Accum: begin
        if (accept && (count_next == CountW'(WINDOW))) begin
          load    = 1'b1;
          state_d = Emit;
        end else if (flush && (count_next != '0)) begin
          // Includes a same-cycle accept; a full window was caught above.
          load         = 1'b1;
          load_partial = 1'b1;
          state_d      = Emit;
        end
      end
      Emit: begin
        if (out_ready) begin
          clear   = 1'b1;
          state_d = Accum;
        end
      end
      default: state_d = Accum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= Accum;
      ready_q       <= 1'b0;
      out_sum_q     <= '0;
      out_max_q     <= '0;
      out_count_q   <= '0;
      out_partial_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (load) begin
        out_sum_q     <= sum_next;
        out_max_q     <= max_next;
        out_count_q   <= count_next;
        out_partial_q <= load_partial;
      end
    end
  end

  assign out_sum     = out_sum_q;
  assign out_max     = out_max_q;
  assign out_count   = out_count_q;
  assign out_partial = out_partial_q;

endmodule

// File: tb/tb_result_window_accum.sv
// Directed and randomized checks of result_window_accum at WINDOW=4, DATA_W=53.
module tb_result_window_accum;

  localparam int unsigned DW  = 53;
  localparam int unsigned WIN = 4;
  localparam int unsigned SW  = 55;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic [DW-1:0] out_max;
  logic [8:0]    out_count;
  logic          out_partial;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  result_window_accum #(
    .DATA_W (DW),
    .WINDOW (WIN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_max     (out_max),
    .out_count   (out_count),
    .out_partial (out_partial)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] v, input bit fl = 1'b0);
    in_valid = 1'b1;
    in_data  = v[DW-1:0];
    flush    = fl;
    cyc();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"},   64'(out_valid),   64'd0);
    chk({tag, ".in_ready"},    64'(in_ready),    64'd0);
    chk({tag, ".out_sum"},     64'(out_sum),     64'd0);
    chk({tag, ".out_max"},     64'(out_max),     64'd0);
    chk({tag, ".out_count"},   64'(out_count),   64'd0);
    chk({tag, ".out_partial"}, 64'(out_partial), 64'd0);
  endtask

  task automatic chk_out(input string tag, input logic [63:0] s, input logic [63:0] m,
                         input logic [63:0] c, input logic [63:0] p);
    chk({tag, ".out_valid"},   64'(out_valid),   64'd1);
    chk({tag, ".in_ready"},    64'(in_ready),    64'd0);
    chk({tag, ".out_sum"},     64'(out_sum),     s);
    chk({tag, ".out_max"},     64'(out_max),     m);
    chk({tag, ".out_count"},   64'(out_count),   c);
    chk({tag, ".out_partial"}, 64'(out_partial), p);
  endtask

  // Check the pending summary, then complete the handshake.
  task automatic expect_emit(input string tag, input logic [63:0] s, input logic [63:0] m,
                             input logic [63:0] c, input logic [63:0] p);
    chk_out(tag, s, m, c, p);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk({tag, ".done_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".done_ready"}, 64'(in_ready),  64'd1);
  endtask

  function automatic void win_stats(input logic [DW-1:0] q[$], output logic [63:0] s,
                                    output logic [63:0] m);
    s = 64'd0;
    m = 64'd0;
    foreach (q[i]) begin
      s += 64'(q[i]);
      if (64'(q[i]) > m) m = 64'(q[i]);
    end
  endfunction

  initial begin
    logic [63:0]   ones;
    logic [63:0]   r;
    logic [63:0]   ps, pm, pc, pp;
    logic [DW-1:0] q[$];
    bit            emitting;

    ones      = (64'd1 << DW) - 64'd1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state and in_ready release timing
    #22;
    chk_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("reset.ready_before_edge", 64'(in_ready), 64'd0);
    cyc();
    chk("reset.ready_after_edge", 64'(in_ready), 64'd1);

    // Full window, back-to-back; out_valid one cycle after final accept
    push(64'd1); push(64'd2); push(64'd3); push(64'd4);
    expect_emit("basic", 64'd10, 64'd4, 64'd4, 64'd0);

    // All-ones samples must not wrap
    repeat (4) push(ones);
    expect_emit("allones", ones * 64'd4, ones, 64'd4, 64'd0);

    // Flush of a partial window, then flush with nothing accumulated
    push(64'd5); push(64'd9);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    expect_emit("flush", 64'd14, 64'd9, 64'd2, 64'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    chk("flush_empty.valid", 64'(out_valid), 64'd0);

    // Back-pressure: outputs hold, input ignored, flush in EMIT forgotten
    push(64'd11); push(64'd3); push(64'd20); push(64'd6);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      r        = {$urandom(), $urandom()};
      in_data  = r[DW-1:0];
      flush    = (k == 2);
      chk_out("stall", 64'd40, 64'd20, 64'd4, 64'd0);
      cyc();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    expect_emit("stall_end", 64'd40, 64'd20, 64'd4, 64'd0);
    push(64'd8);
    cyc();
    chk("emit_flush_forgotten.valid", 64'(out_valid), 64'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    expect_emit("after_stall", 64'd8, 64'd8, 64'd1, 64'd1);

    // Asynchronous reset mid-window discards the partial window
    push(64'd1); push(64'd2); push(64'd3);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid_window");
    #3;
    rst_n = 1'b1;
    cyc();
    chk("rst_mid_window.ready", 64'(in_ready), 64'd1);
    push(64'd1); push(64'd2); push(64'd3); push(64'd4);
    expect_emit("post_reset", 64'd10, 64'd4, 64'd4, 64'd0);

    // Asynchronous reset while a summary is pending
    push(64'd9); push(64'd9); push(64'd9); push(64'd9);
    chk("rst_mid_emit.pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid_emit");
    #3;
    rst_n = 1'b1;
    cyc();
    chk("rst_mid_emit.valid", 64'(out_valid), 64'd0);
    chk("rst_mid_emit.ready", 64'(in_ready),  64'd1);

    // Flush coinciding with an accept
    push(64'd7); push(64'd7); push(64'd7, 1'b1);
    expect_emit("flush_accept", 64'd21, 64'd7, 64'd3, 64'd1);
    push(64'd1); push(64'd1); push(64'd1); push(64'd1, 1'b1);
    expect_emit("flush_full", 64'd4, 64'd1, 64'd4, 64'd0);

    // Random traffic against a queue-based window model
    emitting = 1'b0;
    ps = 64'd0; pm = 64'd0; pc = 64'd0; pp = 64'd0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      r         = {$urandom(), $urandom()};
      in_data   = ($urandom_range(0, 7) == 0) ? ones[DW-1:0] : r[DW-1:0];
      flush     = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      chk("rnd.out_valid", 64'(out_valid), 64'(emitting));
      chk("rnd.in_ready",  64'(in_ready),  64'(!emitting));
      if (emitting) begin
        chk("rnd.out_sum",     64'(out_sum),     ps);
        chk("rnd.out_max",     64'(out_max),     pm);
        chk("rnd.out_count",   64'(out_count),   pc);
        chk("rnd.out_partial", 64'(out_partial), pp);
        if (out_ready) emitting = 1'b0;
      end else begin
        if (in_valid) q.push_back(in_data);
        if (q.size() == WIN || (flush && q.size() > 0)) begin
          win_stats(q, ps, pm);
          pc = 64'(q.size());
          pp = (q.size() != WIN) ? 64'd1 : 64'd0;
          q.delete();
          emitting = 1'b1;
        end
      end
      cyc();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
